// File: rtl/kws_psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller between NUM_REQ requesters, with a watchdog.
// Define KWS_ARB_PRIO_EN to give req 0 fixed top priority (others round-robin among themselves).
module kws_psram_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned AW             = 24,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  req_err,
  output logic [DW-1:0]         rdata,
  output logic                  mem_start,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  input  logic                  mem_done,
  output logic                  busy
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_gnt;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_err;
  logic [DW-1:0]        r_rdata;
  logic                 r_start;
  logic                 r_mem_we;
  logic [AW-1:0]        r_mem_addr;
  logic [DW-1:0]        r_mem_wdata;
  logic                 r_busy;

  logic                 w_any;
  logic [PW-1:0]        w_gnt;
  logic [PW:0]          w_idx;
  logic [PW-1:0]        w_next_ptr;

`ifdef KWS_ARB_PRIO_EN
  logic [PW-1:0]        w_base;

  // req 0 wins outright; otherwise search 1..NUM_REQ-1 starting at the pointer
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_idx  = '0;
    w_base = (r_rr_ptr == '0) ? PW'(1) : r_rr_ptr;
    if (req_valid[0]) begin
      w_any = 1'b1;
    end else begin
      for (int k = int'(NUM_REQ) - 2; k >= 0; k--) begin
        w_idx = {1'b0, w_base} + (PW+1)'(k);
        if (w_idx >= (PW+1)'(NUM_REQ)) w_idx = w_idx - (PW+1)'(NUM_REQ - 1);
        if (req_valid[w_idx[PW-1:0]]) begin
          w_any = 1'b1;
          w_gnt = w_idx[PW-1:0];
        end
      end
    end
  end

  assign w_next_ptr = (r_gnt == '0)                 ? r_rr_ptr :
                      (r_gnt == PW'(NUM_REQ - 1))   ? PW'(1)   : r_gnt + PW'(1);
`else
  // Descending scan so the lowest offset from the pointer is the last (winning) assignment
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NUM_REQ)) w_idx = w_idx - (PW+1)'(NUM_REQ);
      if (req_valid[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_gnt = w_idx[PW-1:0];
      end
    end
  end

  assign w_next_ptr = (r_gnt == PW'(NUM_REQ - 1)) ? '0 : r_gnt + PW'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_start     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt          <= w_gnt;
            r_ack[w_gnt]   <= 1'b1;
            r_mem_we       <= req_we[w_gnt];
            r_mem_addr     <= req_addr[w_gnt*AW +: AW];
            r_mem_wdata    <= req_wdata[w_gnt*DW +: DW];
            r_start        <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (mem_done) begin
            if (!r_mem_we) r_rdata <= mem_rdata;
            r_done[r_gnt] <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_err         <= 1'b1;
            r_done[r_gnt] <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          r_rr_ptr <= w_next_ptr;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack   = r_ack;
  assign req_done  = r_done;
  assign req_err   = r_err;
  assign rdata     = r_rdata;
  assign mem_start = r_start;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_kws_psram_arbiter.sv
// Scoreboard bench for kws_psram_arbiter: directed transactions, PSRAM responder model,
// done-monitor popping expected responses. Honours KWS_ARB_PRIO_EN for the contention phase.
module tb_kws_psram_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     req_done;
  logic              req_err;
  logic [DW-1:0]     rdata;
  logic              mem_start;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_done;
  logic              busy;

  logic              resp_done;
  logic [DW-1:0]     resp_rdata;
  logic              stray;
  logic              hang;
  int                lat;
  logic [DW-1:0]     resp_data;

  assign mem_done  = resp_done | stray;
  assign mem_rdata = stray ? 32'hFFFF0000 : resp_rdata;

  kws_psram_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
    .rdata(rdata), .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        err;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sq[$];
  exp_t mq[$];
  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // PSRAM controller model: checks issued fields, answers after lat cycles unless hung
  initial begin
    resp_done  = 1'b0;
    resp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_start) begin
        if (mq.size() == 0) fail("mem_start_unexpected");
        else begin
          exp_t m;
          m = mq.pop_front();
          chk("start_we",    32'(mem_we),    32'(m.we));
          chk("start_addr",  32'(mem_addr),  32'(m.addr));
          chk("start_wdata", mem_wdata,      m.wdata);
        end
        if (!hang) begin
          repeat (lat) @(negedge clk);
          resp_rdata = resp_data;
          resp_done  = 1'b1;
          @(negedge clk);
          resp_done  = 1'b0;
          resp_rdata = 32'h0;
        end
      end
    end
  end

  // Completion monitor: every req_done pulse is matched against the expected queue
  always @(negedge clk) begin
    if (|req_done) begin
      if (sq.size() == 0) fail("done_unexpected");
      else begin
        exp_t e;
        e = sq.pop_front();
        chk("done_idx",   32'(req_done),  32'(1 << e.idx));
        chk("done_err",   32'(req_err),   32'(e.err));
        chk("done_rdata", rdata,          e.rdata);
        chk("resp_we",    32'(mem_we),    32'(e.we));
        chk("resp_addr",  32'(mem_addr),  32'(e.addr));
        chk("resp_wdata", mem_wdata,      e.wdata);
      end
    end
  end

  task automatic set_fields(input int i, input logic we, input logic [23:0] a, input logic [31:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic push_exp(input int i, input logic we, input logic [23:0] a, input logic [31:0] d,
                          input logic err);
    exp_t e;
    e.idx = i; e.we = we; e.addr = a; e.wdata = d; e.err = err;
    if (!we && !err) last_rd = resp_data;
    e.rdata = last_rd;
    mq.push_back(e);
    sq.push_back(e);
  endtask

  // One isolated transaction; checks ack/start timing and done latency
  task automatic run_single(input int i, input logic we, input logic [23:0] a, input logic [31:0] d,
                            input int l, input logic h, input logic [31:0] rd, input string name);
    int cnt;
    lat = l; hang = h; resp_data = rd;
    set_fields(i, we, a, d);
    push_exp(i, we, a, d, h);
    req_valid[i] = 1'b1;
    @(negedge clk);
    chk({name, "_ack"},   32'(req_ack),   32'(1 << i));
    chk({name, "_start"}, 32'(mem_start), 32'h1);
    chk({name, "_busy"},  32'(busy),      32'h1);
    req_valid[i] = 1'b0;
    cnt = 0;
    while (!(|req_done) && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "_lat"}, 32'(cnt), h ? 32'(TO + 1) : 32'(l + 1));
    @(negedge clk);
    chk({name, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((sq.size() != 0 || busy) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) fail(name);
  endtask

  initial begin
    int acks;
    int cyc;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    stray = 1'b0; hang = 1'b0; lat = 2; resp_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_start", 32'(mem_start), 32'h0);
    chk("rst_ack",   32'(req_ack),   32'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: reset during WAIT abandons the transaction silently
    hang = 1'b1;
    set_fields(0, 1'b1, 24'h0ABCDE, 32'h55AA55AA);
    begin
      exp_t m;
      m.idx = 0; m.we = 1'b1; m.addr = 24'h0ABCDE; m.wdata = 32'h55AA55AA; m.err = 1'b0; m.rdata = 0;
      mq.push_back(m);
    end
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_busy_wait", 32'(busy), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_ack",   32'(req_ack),   32'h0);
    chk("t1_done",  32'(req_done),  32'h0);
    chk("t1_err",   32'(req_err),   32'h0);
    chk("t1_rdata", rdata,          32'h0);
    chk("t1_start", 32'(mem_start), 32'h0);
    chk("t1_we",    32'(mem_we),    32'h0);
    chk("t1_addr",  32'(mem_addr),  32'h0);
    chk("t1_wdata", mem_wdata,      32'h0);
    chk("t1_busy",  32'(busy),      32'h0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t1_still_idle", 32'(busy), 32'h0);

    // T6: write, then a stray mem_done while idle
    run_single(0, 1'b1, 24'h000010, 32'h12345678, 3, 1'b0, 32'hCAFEF00D, "t6");
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("t6_stray_busy",  32'(busy),     32'h0);
    chk("t6_stray_done",  32'(req_done), 32'h0);
    chk("t6_stray_rdata", rdata,         32'h0);

    // T2: single read from req 1
    run_single(1, 1'b0, 24'h000400, 32'h0, 5, 1'b0, 32'hDEADBEEF, "t2");
    chk("t2_rdata_hold", rdata, 32'hDEADBEEF);

    // T3/T4: both requesters contending
    hang = 1'b0; lat = 2; resp_data = 32'h0BADF00D;
    set_fields(0, 1'b1, 24'h000100, 32'hA0A0A0A0);
    set_fields(1, 1'b0, 24'h000400, 32'h0);
`ifdef KWS_ARB_PRIO_EN
    push_exp(0, 1'b1, 24'h000100, 32'hA0A0A0A0, 1'b0);
    push_exp(0, 1'b1, 24'h000100, 32'hA0A0A0A0, 1'b0);
    push_exp(1, 1'b0, 24'h000400, 32'h0, 1'b0);
`else
    push_exp(0, 1'b1, 24'h000100, 32'hA0A0A0A0, 1'b0);
    push_exp(1, 1'b0, 24'h000400, 32'h0, 1'b0);
    push_exp(0, 1'b1, 24'h000100, 32'hA0A0A0A0, 1'b0);
    push_exp(1, 1'b0, 24'h000400, 32'h0, 1'b0);
`endif
    req_valid = 2'b11;
    acks = 0; cyc = 0;
    while (req_valid != 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (|req_ack) acks++;
`ifdef KWS_ARB_PRIO_EN
      if (acks == 2) req_valid[0] = 1'b0;
      if (acks == 3) req_valid = 2'b00;
`else
      if (acks == 4) req_valid = 2'b00;
`endif
    end
    if (cyc >= 200) fail("contention_acks");
    drain("contention_drain");

    // T5: watchdog abort, rdata preserved, then normal recovery
    run_single(0, 1'b0, 24'h000200, 32'h0, 1, 1'b1, 32'h77777777, "t5");
    chk("t5_rdata_kept", rdata, 32'h0BADF00D);
    run_single(1, 1'b0, 24'h000404, 32'h0, 1, 1'b0, 32'h13572468, "t5_recover");
    drain("final_drain");
    chk("queues_empty", 32'(sq.size() + mq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
